// File: rtl/fpga_config_loader.sv
// Streams a bitstream of IN_WIDTH words into CFG_WIDTH frames, strobes one configuration
// chain per frame, then settles and enables the fabric flip-flops.
module fpga_config_loader #(
   parameter int CFG_WIDTH     = 224,
   parameter int NUM_CHAINS    = 43,
   parameter int IN_WIDTH      = 32,
   parameter int SETTLE_CYCLES = 10
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [IN_WIDTH-1:0]   s_data,
   input  logic                  s_last,
   output logic [CFG_WIDTH-1:0]  configs_in,
   output logic [NUM_CHAINS-1:0] configs_en,
   output logic                  ff_en,
   output logic                  rdy,
   output logic                  err
);

   localparam int BEATS = CFG_WIDTH / IN_WIDTH;
   localparam int BW    = $clog2(BEATS + 1);
   localparam int FW    = $clog2(NUM_CHAINS + 1);
   localparam int SW    = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ASSEMBLE, S_WRITE, S_SETTLE, S_ENABLE, S_DONE, S_ERR
   } state_t;

   state_t               state;
   logic [CFG_WIDTH-1:0] frame_q;
   logic [BW-1:0]        beat_cnt;
   logic [FW-1:0]        frame_idx;
   logic [SW-1:0]        settle_cnt;

   logic                 accept;
   logic                 frame_end;
   logic                 stream_end;
   logic [CFG_WIDTH-1:0] next_frame;

   assign accept     = s_valid & s_ready;
   assign frame_end  = (beat_cnt == BW'(BEATS - 1));
   assign stream_end = frame_end && (frame_idx == FW'(NUM_CHAINS - 1));
   // Earlier beats migrate toward the MSBs as new words arrive.
   assign next_frame = {frame_q[CFG_WIDTH-IN_WIDTH-1:0], s_data};

   always_ff @(posedge clock) begin
      if (rst) begin
         state      <= S_IDLE;
         frame_q    <= '0;
         beat_cnt   <= '0;
         frame_idx  <= '0;
         settle_cnt <= '0;
         s_ready    <= 1'b0;
         configs_in <= '0;
         configs_en <= '0;
         ff_en      <= 1'b0;
         rdy        <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state      <= S_ASSEMBLE;
                  s_ready    <= 1'b1;
                  beat_cnt   <= '0;
                  frame_idx  <= '0;
                  settle_cnt <= '0;
                  ff_en      <= 1'b0;
                  rdy        <= 1'b0;
                  err        <= 1'b0;
               end
            end
            S_ASSEMBLE: begin
               if (accept) begin
                  // s_last must coincide exactly with the final beat of the final frame.
                  if (s_last != stream_end) begin
                     state   <= S_ERR;
                     err     <= 1'b1;
                     s_ready <= 1'b0;
                  end else if (frame_end) begin
                     configs_in <= next_frame;
                     configs_en <= NUM_CHAINS'(1) << frame_idx;
                     s_ready    <= 1'b0;
                     beat_cnt   <= '0;
                     state      <= S_WRITE;
                  end else begin
                     frame_q  <= next_frame;
                     beat_cnt <= beat_cnt + BW'(1);
                  end
               end
            end
            S_WRITE: begin
               configs_en <= '0;
               frame_idx  <= frame_idx + FW'(1);
               if (frame_idx == FW'(NUM_CHAINS - 1)) begin
                  state      <= S_SETTLE;
                  settle_cnt <= '0;
               end else begin
                  state   <= S_ASSEMBLE;
                  s_ready <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                  state <= S_ENABLE;
                  ff_en <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            S_ENABLE: begin
               state <= S_DONE;
               rdy   <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fpga_config_loader.md
# fpga_config_loader

Synthesizable configuration loader that sits directly upstream of the `fpga` fabric. It accepts the bitstream as a ready/valid stream of 32-bit words and assembles each CFG_WIDTH-bit frame. It writes frames into successive configuration chains through a one-hot `configs_en`, then waits a settle window, raises `ff_en`, and finally `rdy`. It replaces file-based loading so the fabric can be configured in silicon and in gate-level simulation.

## Interface
- CFG_WIDTH, 224, width of one configuration frame (`configs_in`); must be a multiple of IN_WIDTH
- NUM_CHAINS, 43, number of configuration chains (`configs_en` width) = frames per bitstream
- IN_WIDTH, 32, stream word width
- SETTLE_CYCLES, 10, idle cycles between last frame write and `ff_en` rise (>=1)
- clock  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored otherwise
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts word this cycle
- s_data  in  IN_WIDTH  stream word
- s_last  in  1  marks final word of the whole bitstream
- configs_in  out  CFG_WIDTH  frame presented to fabric
- configs_en  out  NUM_CHAINS  one-hot chain write strobe
- ff_en  out  1  fabric flip-flop enable
- rdy  out  1  fabric configured and running
- err  out  1  framing error (sticky until `start` or `rst`)

## Operation
- States: IDLE, ASSEMBLE, WRITE, SETTLE, ENABLE, DONE, ERR.
- Reset (rst=1 at an edge): state IDLE; configs_in=0, configs_en=0, ff_en=0, rdy=0, s_ready=0, err=0; beat and frame counters 0. Applies from any state, mid-load included; partially assembled frames are discarded.
- IDLE: s_ready=0; `start` -> ASSEMBLE.
- ASSEMBLE: s_ready=1. Each accepted beat (s_valid&s_ready) is shifted into the frame register. The first beat of a frame lands in bits [CFG_WIDTH-1 -: IN_WIDTH]; the last beat lands in [IN_WIDTH-1:0]. BEATS = CFG_WIDTH/IN_WIDTH (7 by default). On the BEATS-th beat the loader loads the full frame into `configs_in`, sets `configs_en` = 1<<frame_idx, and moves to WRITE.
- WRITE: exactly one cycle; s_ready=0. Then configs_en returns to 0 and frame_idx increments. If frame_idx was NUM_CHAINS-1 -> SETTLE, else -> ASSEMBLE. configs_in holds until the next frame write.
- Framing check on every accepted beat:
  - s_last=1 on any beat other than the final beat of frame NUM_CHAINS-1 -> ERR.
  - s_last=0 on that final beat -> ERR.
  - In the error case no `configs_en` strobe is issued for that beat.
- SETTLE: counts SETTLE_CYCLES cycles with all outputs steady -> ENABLE.
- ENABLE: ff_en=1 (stays 1), one cycle -> DONE.
- DONE: rdy=1, ff_en=1 held; s_ready=0.
- ERR: err=1, s_ready=0, configs_en=0, ff_en and rdy unchanged from entry (both 0).
- `start` in DONE or ERR: next cycle ff_en=0, rdy=0, err=0, counters 0, state ASSEMBLE; configs_in holds. `start` in any other state is ignored. `start` and `rst` together: rst wins.

## Timing
- s_ready is registered from state; it is 1 exactly in ASSEMBLE.
- Beat acceptance is the standard handshake; s_valid may be held low arbitrarily (stall) with no state change.
- Edge E accepts the last beat of frame k. After E: configs_in=frame k, configs_en=1<<k. After E+1: configs_en=0, s_ready=1 (or SETTLE if last).
- Minimum load with back-to-back beats: NUM_CHAINS*(BEATS+1) cycles from first accept to final strobe = 344 by default.
- Final strobe cycle W: ff_en rises after edge W+1+SETTLE_CYCLES, and rdy one edge later.
- At most one bit of configs_en is ever set; configs_en is 0 outside WRITE.

## Test plan
- Nominal load: rst, start, 301 beats (43 frames × 7) with s_data = frame index in every word, s_last on beat 301 -> each chain k sees configs_en=1<<k for exactly 1 cycle with configs_in = 224-bit replicate of k; ff_en rises 11 cycles after the last strobe; rdy rises 1 cycle later; err=0.
- Word order: frame 0 beats 0x00000001..0x00000007 -> configs_in = {32'h1,32'h2,...,32'h7} during strobe.
- Stalls: random s_valid gaps of 0–5 cycles -> identical strobe/data sequence to the nominal case; no beat is lost or duplicated.
- Framing errors: s_last on beat 14 -> err=1 after that edge, no strobe for frame 1, s_ready=0. Separately, no s_last on beat 301 -> err=1, ff_en stays 0. Then start -> err=0 and a clean reload succeeds.
- Reset mid-operation: rst during frame 20 assembly -> all outputs 0 next cycle, state IDLE; start plus a full stream reloads from chain 0.
- Reconfigure: start in DONE -> ff_en and rdy drop next cycle; second bitstream loads; rdy returns.
